// File: rtl/statelink_ctrl_pkg.sv
// Shared definitions for the StateLink AXIS stop controller.
//  - state_e: 3-bit state encoding, also visible on the state_o debug port.
//  - DEF_TIMEOUT_CYCLES: default cycle budget for DRAIN / WAIT_ACK / RESUME.
package statelink_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAIN    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_STOPPED  = 3'd3,
    S_RESUME   = 3'd4,
    S_ERROR    = 3'd5
  } state_e;

  localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/statelink_pkt_tracker.sv
// Per-channel AXIS packet-boundary tracker (monitor only, never stalls the stream).
// Ports:
//  axis_clk, axis_rst_n : clock, async active-low reset
//  i_tvalid/i_tready/i_tlast : observed slave-side handshake signals
//  o_in_pkt : 1 while a packet has started but its tlast beat has not been seen
//  o_quiet  : next-cycle value of in_pkt is 0 (channel is at a packet boundary
//             once the current beat completes)
module statelink_pkt_tracker (
  input  logic axis_clk,
  input  logic axis_rst_n,
  input  logic i_tvalid,
  input  logic i_tready,
  input  logic i_tlast,
  output logic o_in_pkt,
  output logic o_quiet
);

  logic w_hs;
  logic w_in_pkt_nxt;
  logic r_in_pkt;

  assign w_hs         = i_tvalid & i_tready;
  assign w_in_pkt_nxt = w_hs ? ~i_tlast : r_in_pkt;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) r_in_pkt <= 1'b0;
    else             r_in_pkt <= w_in_pkt_nxt;
  end

  // Looking at the next value lets a tlast beat in this cycle count as quiet.
  assign o_quiet  = ~w_in_pkt_nxt;
  assign o_in_pkt = r_in_pkt;

endmodule

// File: rtl/statelink_axis_stop_ctrl.sv
// Safe stop/resume sequencer for the StateLink AXIS register-wrapped region.
// Stop: drain every monitored stream to a packet boundary, raise decouple,
// wait for all stop_ack bits. Resume: drop decouple, wait for all acks to clear.
// Ports:
//  axis_clk, axis_rst_n     : clock, async active-low reset
//  cmd_stop, cmd_resume     : 1-cycle command pulses
//  mon_tvalid/tready/tlast  : per-channel stream monitor inputs
//  stop_ack                 : per-channel acknowledge from the wrapped region
//  decouple                 : decouple request (WAIT_ACK, STOPPED, ERROR)
//  stopped, busy            : status flags
//  timeout_err              : sticky, cleared by the next accepted cmd_stop
//  state_o                  : current state (debug)
module statelink_axis_stop_ctrl
  import statelink_ctrl_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              cmd_stop,
  input  logic              cmd_resume,
  input  logic [NUM_CH-1:0] mon_tvalid,
  input  logic [NUM_CH-1:0] mon_tready,
  input  logic [NUM_CH-1:0] mon_tlast,
  input  logic [NUM_CH-1:0] stop_ack,
  output logic              decouple,
  output logic              stopped,
  output logic              busy,
  output logic              timeout_err,
  output logic [2:0]        state_o
);

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [NUM_CH-1:0]    w_in_pkt;
  logic [NUM_CH-1:0]    w_quiet;
  state_e               r_state;
  state_e               w_nxt;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 w_tmo;
  logic                 w_timed;
  logic                 w_set_err;
  logic                 w_clr_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_trk
    statelink_pkt_tracker u_trk (
      .axis_clk  (axis_clk),
      .axis_rst_n(axis_rst_n),
      .i_tvalid  (mon_tvalid[g]),
      .i_tready  (mon_tready[g]),
      .i_tlast   (mon_tlast[g]),
      .o_in_pkt  (w_in_pkt[g]),
      .o_quiet   (w_quiet[g])
    );
  end

  assign w_timed = (r_state == S_DRAIN) || (r_state == S_WAIT_ACK) || (r_state == S_RESUME);
  assign w_tmo   = w_timed && (r_cnt == TMO_LAST);

  // Next-state decode. Within a state the first matching condition wins.
  always_comb begin
    w_nxt     = r_state;
    w_set_err = 1'b0;
    w_clr_err = 1'b0;
    case (r_state)
      S_IDLE: if (cmd_stop) begin
        w_nxt     = S_DRAIN;
        w_clr_err = 1'b1;
      end
      S_DRAIN: begin
        if (cmd_resume)    w_nxt = S_IDLE;
        else if (&w_quiet) w_nxt = S_WAIT_ACK;
        else if (w_tmo) begin
          // Forced decouple mid-packet; flagged so software knows state may be torn.
          w_nxt     = S_WAIT_ACK;
          w_set_err = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (&stop_ack)       w_nxt = S_STOPPED;
        else if (cmd_resume) w_nxt = S_RESUME;
        else if (w_tmo) begin
          w_nxt     = S_ERROR;
          w_set_err = 1'b1;
        end
      end
      S_STOPPED, S_ERROR: if (cmd_resume) w_nxt = S_RESUME;
      S_RESUME: begin
        if (~|stop_ack) w_nxt = S_IDLE;
        else if (w_tmo) begin
          w_nxt     = S_IDLE;
          w_set_err = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      decouple    <= 1'b0;
      stopped     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      decouple <= (w_nxt == S_WAIT_ACK) || (w_nxt == S_STOPPED) || (w_nxt == S_ERROR);
      stopped  <= (w_nxt == S_STOPPED);
      busy     <= (w_nxt == S_DRAIN) || (w_nxt == S_WAIT_ACK) || (w_nxt == S_RESUME);
      if (w_set_err)      timeout_err <= 1'b1;
      else if (w_clr_err) timeout_err <= 1'b0;
      // Saturate at the terminal count rather than wrapping.
      if (w_nxt != r_state)     r_cnt <= '0;
      else if (w_timed && !w_tmo) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_statelink_axis_stop_ctrl.sv
module tb_statelink_axis_stop_ctrl;

  localparam int NUM_CH = 2;

  logic              axis_clk = 1'b0;
  logic              axis_rst_n;
  logic              cmd_stop, cmd_resume;
  logic [NUM_CH-1:0] mon_tvalid, mon_tready, mon_tlast, stop_ack;
  logic              decouple, stopped, busy, timeout_err;
  logic [2:0]        state_o;

  int checks   = 0;
  int failures = 0;

  statelink_axis_stop_ctrl #(
    .NUM_CH(NUM_CH), .TIMEOUT_W(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .cmd_stop(cmd_stop), .cmd_resume(cmd_resume),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .stop_ack(stop_ack),
    .decouple(decouple), .stopped(stopped), .busy(busy),
    .timeout_err(timeout_err), .state_o(state_o)
  );

  always #5 axis_clk = ~axis_clk;

  // Expected output word: {decouple, stopped, busy, timeout_err, state[2:0]}
  function automatic logic [6:0] e(input logic dc, input logic st, input logic bz,
                                   input logic er, input logic [2:0] s);
    return {dc, st, bz, er, s};
  endfunction

  typedef struct {
    logic       stop, res;
    logic [1:0] tv, tr, tl, ack;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic cmp(input string nm, input logic [6:0] exp);
    logic [6:0] got;
    got = {decouple, stopped, busy, timeout_err, state_o};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got {dec,stp,busy,err,st}=%b required %b", nm, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic [1:0] tv,
                       input logic [1:0] tr, input logic [1:0] tl, input logic [1:0] ack);
    cmd_stop = s; cmd_resume = r;
    mon_tvalid = tv; mon_tready = tr; mon_tlast = tl; stop_ack = ack;
  endtask

  // Apply current inputs across one rising edge, then compare.
  task automatic tick(input string nm, input logic [6:0] exp);
    @(posedge axis_clk); #1;
    cmp(nm, exp);
  endtask

  initial begin
    axis_rst_n = 1'b0;
    drive(0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    #3 cmp("reset_state", e(0,0,0,0,0));
    repeat (2) @(negedge axis_clk);
    axis_rst_n = 1'b1;

    // stop/ack/resume walk, command priorities, resume-in-drain abort
    tbl.push_back('{1,0,2'b00,2'b00,2'b00,2'b00, e(0,0,1,0,1)}); // stop@N -> DRAIN, busy@N+1
    tbl.push_back('{0,0,2'b00,2'b00,2'b00,2'b00, e(1,0,1,0,2)}); // quiet -> WAIT_ACK, decouple@N+2
    tbl.push_back('{0,0,2'b00,2'b00,2'b00,2'b01, e(1,0,1,0,2)}); // partial ack holds
    tbl.push_back('{0,0,2'b00,2'b00,2'b00,2'b10, e(1,0,1,0,2)}); // partial ack holds
    tbl.push_back('{0,0,2'b00,2'b00,2'b00,2'b11, e(1,1,0,0,3)}); // ack@N+4 -> stopped@N+5
    tbl.push_back('{1,0,2'b00,2'b00,2'b00,2'b11, e(1,1,0,0,3)}); // stop ignored in STOPPED
    tbl.push_back('{0,1,2'b00,2'b00,2'b00,2'b11, e(0,0,1,0,4)}); // resume -> RESUME, decouple 0
    tbl.push_back('{0,0,2'b00,2'b00,2'b00,2'b11, e(0,0,1,0,4)});
    tbl.push_back('{0,0,2'b00,2'b00,2'b00,2'b11, e(0,0,1,0,4)});
    tbl.push_back('{0,0,2'b00,2'b00,2'b00,2'b00, e(0,0,0,0,0)}); // acks clear -> IDLE
    tbl.push_back('{0,1,2'b00,2'b00,2'b00,2'b00, e(0,0,0,0,0)}); // resume ignored in IDLE
    tbl.push_back('{0,0,2'b10,2'b10,2'b00,2'b00, e(0,0,0,0,0)}); // ch1 packet starts
    tbl.push_back('{1,0,2'b00,2'b00,2'b00,2'b00, e(0,0,1,0,1)}); // stop -> DRAIN
    tbl.push_back('{0,0,2'b01,2'b00,2'b00,2'b00, e(0,0,1,0,1)}); // ch1 open, ch0 no handshake
    tbl.push_back('{1,0,2'b00,2'b00,2'b00,2'b00, e(0,0,1,0,1)}); // stop ignored in DRAIN
    tbl.push_back('{0,1,2'b00,2'b00,2'b00,2'b00, e(0,0,0,0,0)}); // resume in DRAIN -> IDLE
    tbl.push_back('{0,0,2'b10,2'b10,2'b10,2'b00, e(0,0,0,0,0)}); // ch1 tlast closes packet
    tbl.push_back('{1,1,2'b00,2'b00,2'b00,2'b00, e(0,0,1,0,1)}); // both cmds in IDLE: stop wins
    tbl.push_back('{0,0,2'b00,2'b00,2'b00,2'b00, e(1,0,1,0,2)});
    tbl.push_back('{0,1,2'b00,2'b00,2'b00,2'b00, e(0,0,1,0,4)}); // resume in WAIT_ACK
    tbl.push_back('{0,0,2'b00,2'b00,2'b00,2'b00, e(0,0,0,0,0)});

    foreach (tbl[i]) begin
      drive(tbl[i].stop, tbl[i].res, tbl[i].tv, tbl[i].tr, tbl[i].tl, tbl[i].ack);
      tick($sformatf("row%0d", i), tbl[i].exp);
    end

    // ch0 3-beat packet spanning the stop: DRAIN until the tlast beat
    drive(0,0,2'b01,2'b01,2'b00,2'b00); tick("pkt_beat1", e(0,0,0,0,0));
    drive(1,0,2'b00,2'b00,2'b00,2'b00); tick("pkt_stop",  e(0,0,1,0,1));
    drive(0,0,2'b00,2'b00,2'b00,2'b00); tick("pkt_d1",    e(0,0,1,0,1));
    tick("pkt_d2", e(0,0,1,0,1));
    drive(0,0,2'b01,2'b01,2'b00,2'b00); tick("pkt_beat2", e(0,0,1,0,1));
    drive(0,0,2'b01,2'b00,2'b01,2'b00); tick("pkt_stall1", e(0,0,1,0,1));
    tick("pkt_stall2", e(0,0,1,0,1));
    drive(0,0,2'b01,2'b01,2'b01,2'b00); tick("pkt_beat3", e(1,0,1,0,2));
    drive(0,0,2'b00,2'b00,2'b00,2'b11); tick("pkt_stopped", e(1,1,0,0,3));
    drive(0,1,2'b00,2'b00,2'b00,2'b11); tick("pkt_resume",  e(0,0,1,0,4));
    drive(0,0,2'b00,2'b00,2'b00,2'b00); tick("pkt_idle",    e(0,0,0,0,0));

    // WAIT_ACK timeout with stuck partial ack, then RESUME timeout
    drive(1,0,2'b00,2'b00,2'b00,2'b01); tick("tmo_drain", e(0,0,1,0,1));
    drive(0,0,2'b00,2'b00,2'b00,2'b01); tick("tmo_wait_entry", e(1,0,1,0,2));
    for (int k = 1; k <= 8; k++)
      tick($sformatf("tmo_wait_%0d", k), (k == 8) ? e(1,0,0,1,5) : e(1,0,1,0,2));
    drive(1,0,2'b00,2'b00,2'b00,2'b01); tick("err_stop_ignored", e(1,0,0,1,5));
    drive(0,1,2'b00,2'b00,2'b00,2'b01); tick("err_resume", e(0,0,1,1,4));
    drive(0,0,2'b00,2'b00,2'b00,2'b01);
    for (int k = 1; k <= 8; k++)
      tick($sformatf("tmo_resume_%0d", k), (k == 8) ? e(0,0,0,1,0) : e(0,0,1,1,4));
    drive(1,0,2'b00,2'b00,2'b00,2'b00); tick("err_cleared_by_stop", e(0,0,1,0,1));
    drive(0,0,2'b00,2'b00,2'b00,2'b00); tick("rst_wait_entry", e(1,0,1,0,2));

    // async reset during WAIT_ACK with ch0 mid-packet
    drive(0,0,2'b01,2'b01,2'b00,2'b00); tick("rst_pkt_open", e(1,0,1,0,2));
    drive(0,0,2'b00,2'b00,2'b00,2'b00);
    #2 axis_rst_n = 1'b0;
    #1 cmp("rst_async_drop", e(0,0,0,0,0));
    tick("rst_held", e(0,0,0,0,0));
    #3 axis_rst_n = 1'b1;
    drive(1,0,2'b00,2'b00,2'b00,2'b00); tick("post_rst_stop", e(0,0,1,0,1));
    drive(0,0,2'b00,2'b00,2'b00,2'b00); tick("post_rst_inpkt_clr", e(1,0,1,0,2));
    drive(0,0,2'b00,2'b00,2'b00,2'b11); tick("post_rst_stopped", e(1,1,0,0,3));
    drive(0,1,2'b00,2'b00,2'b00,2'b11); tick("post_rst_resume", e(0,0,1,0,4));
    drive(0,0,2'b00,2'b00,2'b00,2'b00); tick("post_rst_idle", e(0,0,0,0,0));

    // DRAIN timeout: ch1 never finishes, forced to WAIT_ACK with error
    drive(0,0,2'b10,2'b10,2'b00,2'b00); tick("dtmo_open", e(0,0,0,0,0));
    drive(1,0,2'b00,2'b00,2'b00,2'b00); tick("dtmo_stop", e(0,0,1,0,1));
    drive(0,0,2'b00,2'b00,2'b00,2'b00);
    for (int k = 1; k <= 8; k++)
      tick($sformatf("dtmo_%0d", k), (k == 8) ? e(1,0,1,1,2) : e(0,0,1,0,1));
    drive(0,0,2'b00,2'b00,2'b00,2'b11); tick("dtmo_stopped", e(1,1,0,1,3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
